// File: rtl/single_fetch.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one imem read at a time
// over req/ack, and holds the returned word for decode under valid/ready.
module single_fetch #(
  parameter int N = 9,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_data,
  output logic [W-1:0] ins,
  output logic [N-1:0] ins_pc,
  output logic         ins_valid,
  input  logic         ins_ready,
  input  logic         br_taken,
  input  logic [N-1:0] br_target
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] pc;

  // The request address is the fetch PC itself, so it is stable for the whole request.
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      imem_req  <= 1'b0;
      ins       <= '0;
      ins_pc    <= '0;
      ins_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            ins       <= imem_data;
            ins_pc    <= pc;
            ins_valid <= 1'b1;
            imem_req  <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // Branch inputs only matter on the handshake edge; no wrong-path fetch occurs.
          if (ins_valid && ins_ready) begin
            ins_valid <= 1'b0;
            pc        <= br_taken ? br_target : pc + N'(1);
            imem_req  <= 1'b1;
            state     <= REQ;
          end
        end
        default: begin
          state     <= IDLE;
          imem_req  <= 1'b0;
          ins_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
